// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-line bundle between a word source and seq_pattern_tx.
// The master side offers words and paces bits; the slave side is the transmitter.
interface seq_pattern_tx_if #(
    parameter int DATA_W = 8
);
    logic              bit_en;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              dout;
    logic              busy;
    logic              frame_done;

    modport master (
        output bit_en, tx_valid, tx_data,
        input  tx_ready, dout, busy, frame_done
    );

    modport slave (
        input  bit_en, tx_valid, tx_data,
        output tx_ready, dout, busy, frame_done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload, optional even
// parity and trailing zero gap, one bit per bit_en tick.
//
//   state | meaning
//   IDLE  | line held at 0, waiting for tx_valid
//   SYNC  | shifting out the sync pattern
//   DATA  | shifting out the payload
//   PAR   | sending the even-parity bit
//   GAP   | sending zeros that return the detector to idle
module seq_pattern_tx #(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT       = 4'b1101,
    parameter int               DATA_W    = 8,
    parameter bit               PARITY_EN = 1'b1,
    parameter int               GAP_BITS  = 2
) (
    input  logic            clk,
    input  logic            clr,
    seq_pattern_tx_if.slave bus
);
    localparam int SH_W  = PAT_W + DATA_W;
    localparam int MAX_A = (PAT_W > DATA_W) ? PAT_W : DATA_W;
    localparam int MAX_C = (MAX_A > GAP_BITS) ? MAX_A : GAP_BITS;
    localparam int CNT_W = $clog2(MAX_C);

    localparam logic [CNT_W-1:0] SYNC_TC = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] DATA_TC = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t            state;
    logic [SH_W-1:0]   shift;
    logic [CNT_W-1:0]  cnt;
    logic              parity;
    logic              dout_q;
    logic              frame_done_q;

    // Pattern and payload share one shift register so SYNC and DATA both
    // just drive the MSB and shift left; cnt is a down-counter per segment.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            shift        <= '0;
            cnt          <= '0;
            parity       <= 1'b0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    dout_q <= 1'b0;
                    if (bus.tx_valid) begin
                        shift  <= {PAT, bus.tx_data};
                        parity <= ^bus.tx_data;
                        cnt    <= SYNC_TC;
                        state  <= SYNC;
                    end
                end
                SYNC, DATA: begin
                    if (bus.bit_en) begin
                        dout_q <= shift[SH_W-1];
                        shift  <= shift << 1;
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (state == SYNC) begin
                            cnt   <= DATA_TC;
                            state <= DATA;
                        end else if (PARITY_EN) begin
                            state <= PAR;
                        end else begin
                            cnt   <= GAP_TC;
                            state <= GAP;
                        end
                    end
                end
                PAR: begin
                    if (bus.bit_en) begin
                        dout_q <= parity;
                        cnt    <= GAP_TC;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    if (bus.bit_en) begin
                        dout_q <= 1'b0;
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state        <= IDLE;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    dout_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_ready   = (state == IDLE) && !clr;
    assign bus.busy       = (state != IDLE);
    assign bus.dout       = dout_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed frames plus randomized
// payloads and bit pacing, compared against a bit-list frame model.
module tb_seq_pattern_tx;
    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.DATA_W(8)) bus_a ();
    seq_pattern_tx_if #(.DATA_W(4)) bus_b ();

    seq_pattern_tx #(
        .PAT_W(4), .PAT(4'b1101), .DATA_W(8), .PARITY_EN(1'b1), .GAP_BITS(2)
    ) dut_a (.clk(clk), .clr(clr), .bus(bus_a));

    seq_pattern_tx #(
        .PAT_W(4), .PAT(4'b1101), .DATA_W(4), .PARITY_EN(1'b0), .GAP_BITS(2)
    ) dut_b (.clk(clk), .clr(clr), .bus(bus_b));

    int         checks = 0;
    int         errors = 0;
    bit         exp_q[$];
    bit         line_q[$];
    logic [3:0] pat_v = 4'b1101;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic v, input logic [7:0] d, input logic en);
        if (s) begin
            bus_b.tx_valid = v; bus_b.tx_data = d[3:0]; bus_b.bit_en = en;
        end else begin
            bus_a.tx_valid = v; bus_a.tx_data = d;      bus_a.bit_en = en;
        end
    endtask

    // {tx_ready, dout, busy, frame_done}
    function automatic logic [3:0] obs(input bit s);
        if (s) return {bus_b.tx_ready, bus_b.dout, bus_b.busy, bus_b.frame_done};
        return {bus_a.tx_ready, bus_a.dout, bus_a.busy, bus_a.frame_done};
    endfunction

    // Expected line bits for one frame: pattern, payload MSB first, parity, 2 zeros.
    task automatic make_frame(input logic [7:0] d, input int dw, input bit par);
        int ones;
        ones = 0;
        exp_q.delete();
        for (int i = 3; i >= 0; i--) exp_q.push_back(pat_v[i]);
        for (int i = dw - 1; i >= 0; i--) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par) exp_q.push_back((ones % 2) == 1);
        repeat (2) exp_q.push_back(1'b0);
    endtask

    // period 0 = random bit_en, otherwise bit_en every period-th clk.
    task automatic frame(input bit s, input logic [7:0] d, input int period,
                         input bit hold, input logic [7:0] nxt, input string tag);
        logic [3:0] o;
        logic       en, prev;
        int         k, cyc;
        k = 0; cyc = 0;
        o = obs(s);
        chk({tag, "/ready_before"}, 32'(o[3]), 1);
        drive(s, 1'b1, d, 1'b1);
        tick();
        drive(s, hold, hold ? nxt : ~d, 1'b0);
        o = obs(s);
        chk({tag, "/accept_dout"}, 32'(o[2]), 0);
        chk({tag, "/accept_busy"}, 32'(o[1]), 1);
        chk({tag, "/accept_done"}, 32'(o[0]), 0);
        make_frame(d, s ? 4 : 8, !s);
        while (k < exp_q.size() && cyc < 2000) begin
            cyc++;
            en = (period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % period) == 0);
            drive(s, hold, hold ? nxt : ~d, en);
            prev = o[2];
            tick();
            o = obs(s);
            if (en) begin
                chk($sformatf("%s/bit%0d", tag, k), 32'(o[2]), 32'(exp_q[k]));
                line_q.push_back(o[2]);
                k++;
            end else begin
                chk({tag, "/stall_hold"}, 32'(o[2]), 32'(prev));
            end
            if (k < exp_q.size()) begin
                chk({tag, "/busy_mid"}, 32'(o[1]), 1);
                chk({tag, "/done_mid"}, 32'(o[0]), 0);
            end
        end
        chk({tag, "/bit_count"}, 32'(k), 32'(exp_q.size()));
        chk({tag, "/done_pulse"}, 32'(o[0]), 1);
        chk({tag, "/busy_end"},   32'(o[1]), 0);
        chk({tag, "/ready_end"},  32'(o[3]), 1);
        drive(s, hold, nxt, 1'b0);
    endtask

    initial begin
        logic [3:0] o;
        logic [7:0] rd;
        int         hits;

        clr = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);

        // Reset
        repeat (3) tick();
        o = obs(0);
        chk("rst/dout",  32'(o[2]), 0);
        chk("rst/busy",  32'(o[1]), 0);
        chk("rst/ready", 32'(o[3]), 0);
        chk("rst/done",  32'(o[0]), 0);
        o = obs(1);
        chk("rst_b/ready", 32'(o[3]), 0);
        clr = 1'b0;
        #1;
        chk("rst/ready_release", 32'(bus_a.tx_ready), 1);
        tick();

        frame(0, 8'hA5, 1, 0, 8'h00, "t2");
        frame(0, 8'h07, 3, 0, 8'h00, "t3");

        // Back-to-back with tx_valid held; detector counts sync hits on the line.
        line_q.delete();
        frame(0, 8'h3C, 1, 1, 8'hC3, "t4a");
        frame(0, 8'hC3, 1, 0, 8'h00, "t4b");
        hits = 0;
        for (int i = 0; i + 3 < line_q.size(); i++)
            if ({line_q[i], line_q[i+1], line_q[i+2], line_q[i+3]} == pat_v) hits++;
        chk("t4/detector_hits", 32'(hits), 2);
        chk("t4/line_len", 32'(line_q.size()), 30);

        // clr after the 6th bit edge of 8'hFF
        o = obs(0);
        chk("t5/ready_before", 32'(o[3]), 1);
        drive(0, 1'b1, 8'hFF, 1'b0);
        tick();
        drive(0, 1'b0, 8'h00, 1'b1);
        make_frame(8'hFF, 8, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            o = obs(0);
            chk($sformatf("t5/bit%0d", k), 32'(o[2]), 32'(exp_q[k]));
        end
        #2 clr = 1'b1;
        #1;
        o = obs(0);
        chk("t5/clr_dout",  32'(o[2]), 0);
        chk("t5/clr_busy",  32'(o[1]), 0);
        chk("t5/clr_ready", 32'(o[3]), 0);
        chk("t5/clr_done",  32'(o[0]), 0);
        tick();
        chk("t5/clr_done2", 32'(bus_a.frame_done), 0);
        clr = 1'b0;
        #1;
        chk("t5/ready_release", 32'(bus_a.tx_ready), 1);
        tick();
        o = obs(0);
        chk("t5/idle_dout", 32'(o[2]), 0);
        chk("t5/idle_busy", 32'(o[1]), 0);
        chk("t5/idle_done", 32'(o[0]), 0);
        frame(0, 8'h00, 1, 0, 8'h00, "t5_next");

        frame(1, 8'h0B, 1, 0, 8'h00, "t6");

        // Randomized payloads, pacing and hold
        repeat (6) begin
            rd = 8'($urandom);
            frame(0, rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom), "rnd_a");
        end
        repeat (4) begin
            rd = 8'($urandom);
            frame(1, {4'h0, rd[3:0]}, $urandom_range(0, 2), 1'b0, 8'h00, "rnd_b");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
